spc_cfg_master: RTL
===================

# spc_cfg_master

Configuration master for the BIO IC serial-to-parallel converter: it accepts an 11-bit configuration word from the on-chip or host-side control logic and plays it out as the serial Cfg_in/Clk/Strobe sequence the converter expects. It runs on the system clock, with a programmable divider for the serial clock, and sits between the register/command interface and the analog-front-end configuration chain. A start/busy/done handshake lets the issuing logic sequence gain, frequency and calibration changes.

## Interface
- WIDTH, 11: configuration word length in bits; equals the converter shift-chain length.
- DIV, 4: half-period of Sclk in Clk cycles; legal range 1..255.
- Clk  input  1  system clock; all logic on the rising edge.
- Resetn  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request; sampled only when busy=0.
- cfg_word  input  WIDTH  word to send. Field map: [10:7]=F, [6]=IQ, [5:3]=G, [2]=CE, [1:0]=GCP.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at the end of a frame.
- Cfg_out  output  1  serial data; connects to the converter's Cfg_in.
- Sclk  output  1  serial shift clock; connects to the converter's Clk.
- Strobe_out  output  1  parallel-load strobe; connects to the converter's Strobe.

## Operation
- FSM states: IDLE, BIT_LO, BIT_HI, STB_LO, STB_HI, DONE.
- IDLE with start=1: latch cfg_word into the shift register, load bit counter = WIDTH-1 and divider = DIV-1, then go to BIT_LO.
- BIT_LO: Sclk=0 and Cfg_out=shreg[0]. When the divider expires, go to BIT_HI.
- BIT_HI: Sclk=1, with data held stable. When the divider expires:
  - if bit counter = 0, go to STB_LO;
  - otherwise shift shreg right, decrement the counter and go to BIT_LO.
- Bit order is LSB first. cfg_word[0] is sent first and ends in converter bit 0 (GCP[0]); cfg_word[10] is sent last (F[3]).
- STB_LO: Sclk=0, Cfg_out=0, for DIV cycles.
- STB_HI: Strobe_out=1 for DIV cycles.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in the DONE cycle is accepted the same as in IDLE.
- busy is asserted in every state except IDLE and DONE.
- Without the macro, start while busy=1 is ignored. cfg_word changes while busy do not affect the frame in flight.
- All outputs come straight from flops, so they are glitch-free. Sclk and Strobe_out are never high at the same time.

## Timing
- Reset values: busy=0, done=0, Cfg_out=0, Sclk=0, Strobe_out=0, state=IDLE, shreg=0. The converter shares Resetn, so both sides clear together.
- Cycle 0 is the edge that samples start. From cycle 1:
  - bit k is driven on Cfg_out during cycles 1+2kDIV through 2(k+1)DIV;
  - Sclk rises at 1+(2k+1)DIV, giving DIV cycles of setup and DIV cycles of hold.
- Strobe_out is high during cycles 1+2WIDTH·DIV+DIV through 2WIDTH·DIV+2DIV.
- done is high at cycle 1+2DIV(WIDTH+1). With defaults that is cycle 97.
- DIV=1: Sclk toggles every Clk cycle, and the same equations hold.
- Resetn asserted mid-frame: immediate return to IDLE with all outputs at reset values. No partial strobe is ever issued.

## Configuration
- SPC_CFG_SHADOW_EN defined:
  - adds a one-deep shadow register and a pending flag;
  - start while busy captures cfg_word into the shadow and sets pending; a later start while pending overwrites the shadow (last wins);
  - in the DONE cycle with pending=1, the shadow is loaded, pending is cleared, and BIT_LO is entered next cycle, so busy stays 0 for only the DONE cycle;
  - a start in the same DONE cycle takes priority over the shadow and clears pending.
- SPC_CFG_SHADOW_EN undefined: no shadow logic; start while busy is dropped.

## Structure
- Package spc_cfg_pkg holds:
  - the state enum;
  - field offset/width constants F_LSB=7, IQ_BIT=6, G_LSB=3, CE_BIT=2, GCP_LSB=0, and SPC_WIDTH=11.
- Sub-module spc_cfg_tick: a DIV-cycle down-counter with a load input and an expire pulse. It is reused for every half-period.

## Test plan
- Reset, then start with cfg_word=11'h5A3 and DIV=4 -> Cfg_out sequence 1,1,0,0,0,1,0,1,1,0,1 at the Sclk rising edges; Strobe_out high cycles 93–96; done at cycle 97; a converter model outputs F=4'hB, IQ=0, G=3'b100, CE=0, GCP=2'b11.
- DIV=1 with cfg_word=11'h7FF -> 11 Sclk pulses each 1 cycle high; done at cycle 25; all converter fields all-ones.
- start pulsed at cycle 40 of a frame (macro off) -> ignored; exactly one frame, one done.
- Macro on: second start at cycle 40 with 11'h001 -> second frame's bit 0 driven in the cycle after done; converter shows GCP=2'b01 after the second strobe.
- Resetn low at cycle 50 -> all outputs 0 within the reset; no Strobe_out pulse; a subsequent start produces a complete normal frame.
- Back-to-back: start asserted in the done cycle -> accepted, with bit 0 driven in the next cycle.

Source files
------------

// File: rtl/spc_cfg_pkg.sv
// Shared types and constants for the BIO IC serial-to-parallel converter configuration master.
// Field layout of the converter's 11-bit configuration word.
package spc_cfg_pkg;

   localparam int SPC_WIDTH = 11;

   localparam int F_LSB     = 7;
   localparam int F_WIDTH   = 4;
   localparam int IQ_BIT    = 6;
   localparam int G_LSB     = 3;
   localparam int G_WIDTH   = 3;
   localparam int CE_BIT    = 2;
   localparam int GCP_LSB   = 0;
   localparam int GCP_WIDTH = 2;

   typedef enum logic [2:0] {
      IDLE,
      BIT_LO,
      BIT_HI,
      STB_LO,
      STB_HI,
      DONE
   } state_t;

endpackage

// File: rtl/spc_cfg_tick.sv
// Half-period timer: counts DIV cycles after each load and flags expiry on the last one.
// A load while expired restarts the next half-period without a gap cycle.
module spc_cfg_tick #(
   parameter int DIV = 4
) (
   input  logic Clk,
   input  logic Resetn,
   input  logic load,
   output logic expire
);

   localparam logic [7:0] RELOAD = 8'(DIV - 1);

   logic [7:0] cnt_reg;

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         cnt_reg <= RELOAD;
      end else if (load) begin
         cnt_reg <= RELOAD;
      end else if (cnt_reg != 8'd0) begin
         cnt_reg <= cnt_reg - 8'd1;
      end
   end

   assign expire = (cnt_reg == 8'd0);

endmodule

// File: rtl/spc_cfg_master.sv
// Plays an 11-bit configuration word out as Cfg_in/Clk/Strobe to the converter, LSB first.
// Optional SPC_CFG_SHADOW_EN: one-deep shadow queues a start issued while a frame is in flight.
module spc_cfg_master
   import spc_cfg_pkg::*;
#(
   parameter int WIDTH = SPC_WIDTH,
   parameter int DIV   = 4
) (
   input  logic             Clk,
   input  logic             Resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] cfg_word,
   output logic             busy,
   output logic             done,
   output logic             Cfg_out,
   output logic             Sclk,
   output logic             Strobe_out
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shreg_reg, shreg_next;
   logic [CW-1:0]    bitcnt_reg, bitcnt_next;
   logic             busy_reg, done_reg, cfg_out_reg, sclk_reg, strobe_reg;
   logic             expire, in_frame, tick_load;

   assign in_frame  = (state_reg != IDLE) && (state_reg != DONE);
   // Outside a frame the timer is held at reload so the first half-period is a full DIV.
   assign tick_load = expire || !in_frame;

   spc_cfg_tick #(.DIV(DIV)) u_tick (
      .Clk    (Clk),
      .Resetn (Resetn),
      .load   (tick_load),
      .expire (expire)
   );

`ifdef SPC_CFG_SHADOW_EN
   logic [WIDTH-1:0] shadow_reg, shadow_next;
   logic             pending_reg, pending_next;

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         shadow_reg  <= '0;
         pending_reg <= 1'b0;
      end else begin
         shadow_reg  <= shadow_next;
         pending_reg <= pending_next;
      end
   end
`endif

   always_comb begin
      state_next  = state_reg;
      shreg_next  = shreg_reg;
      bitcnt_next = bitcnt_reg;
`ifdef SPC_CFG_SHADOW_EN
      shadow_next  = shadow_reg;
      pending_next = pending_reg;
      if (in_frame && start) begin
         shadow_next  = cfg_word;
         pending_next = 1'b1;
      end
`endif
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next  = BIT_LO;
               shreg_next  = cfg_word;
               bitcnt_next = LAST_BIT;
            end
         end
         BIT_LO: begin
            if (expire) state_next = BIT_HI;
         end
         BIT_HI: begin
            if (expire) begin
               if (bitcnt_reg == '0) begin
                  state_next = STB_LO;
               end else begin
                  state_next  = BIT_LO;
                  shreg_next  = shreg_reg >> 1;
                  bitcnt_next = bitcnt_reg - CW'(1);
               end
            end
         end
         STB_LO: begin
            if (expire) state_next = STB_HI;
         end
         STB_HI: begin
            if (expire) state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
            if (start) begin
               state_next  = BIT_LO;
               shreg_next  = cfg_word;
               bitcnt_next = LAST_BIT;
            end
`ifdef SPC_CFG_SHADOW_EN
            else if (pending_reg) begin
               state_next  = BIT_LO;
               shreg_next  = shadow_reg;
               bitcnt_next = LAST_BIT;
            end
            pending_next = 1'b0;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_reg  <= IDLE;
         shreg_reg  <= '0;
         bitcnt_reg <= '0;
      end else begin
         state_reg  <= state_next;
         shreg_reg  <= shreg_next;
         bitcnt_reg <= bitcnt_next;
      end
   end

   // Outputs are registered from the next state so pins line up with the state they describe.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         cfg_out_reg <= 1'b0;
         sclk_reg    <= 1'b0;
         strobe_reg  <= 1'b0;
      end else begin
         busy_reg    <= (state_next != IDLE) && (state_next != DONE);
         done_reg    <= (state_next == DONE);
         cfg_out_reg <= ((state_next == BIT_LO) || (state_next == BIT_HI)) && shreg_next[0];
         sclk_reg    <= (state_next == BIT_HI);
         strobe_reg  <= (state_next == STB_HI);
      end
   end

   assign busy       = busy_reg;
   assign done       = done_reg;
   assign Cfg_out    = cfg_out_reg;
   assign Sclk       = sclk_reg;
   assign Strobe_out = strobe_reg;

endmodule
